// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial unsigned adder, one full-add cell plus carry flop
// Operands are added LSB-first, one bit per clock; the result is held until the next accepted start.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_n;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sr, b_sr;
   logic             carry;
   logic             s, carry_n, last;

   always_comb begin
      s       = a_sr[0] ^ b_sr[0] ^ carry;
      carry_n = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
      last    = (cnt == CW'(WIDTH - 1));
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = RUN;
         RUN:     if (last) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Sum fills from the MSB side, so after WIDTH shifts bit 0 holds the first computed bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr  <= '0;
         b_sr  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  carry <= 1'b0;
                  cnt   <= '0;
               end
            end
            RUN: begin
               sum   <= {s, sum[WIDTH-1:1]};
               carry <= carry_n;
               a_sr  <= a_sr >> 1;
               b_sr  <= b_sr >> 1;
               cnt   <= cnt + 1'b1;
               if (last) cout <= carry_n;
            end
            default: ;
         endcase
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule
